// File: rtl/radio_pkg.sv
// Shared audio types, I2S frame constants and the 16-bit saturation helper.
package radio_pkg;

    localparam int unsigned AUDIO_W      = 16;
    localparam int unsigned DEEMPH_ALPHA = 15227;
    localparam int unsigned BCLK_HALF    = 75;
    localparam int unsigned SLOT_BITS    = 25;
    localparam int unsigned FRAME_BITS   = 2 * SLOT_BITS;
    localparam int unsigned FIFO_DEPTH   = 4;
    localparam int unsigned PREFILL      = 2;

    typedef logic signed [AUDIO_W-1:0] sample_t;

    typedef enum logic {IDLE, RUN} i2s_state_t;

    function automatic sample_t sat16(input logic signed [32:0] v);
        if (v > 33'sd32767) begin
            return 16'sh7FFF;
        end
        if (v < -33'sd32768) begin
            return 16'sh8000;
        end
        return sample_t'(v[15:0]);
    endfunction

endpackage

// File: rtl/sample_fifo.sv
// Synchronous first-word-fall-through FIFO; DEPTH must be a power of two.
module sample_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   push_i,
    input  logic [W-1:0]           din_i,
    input  logic                   pop_i,
    output logic [W-1:0]           dout_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   full_o,
    output logic                   empty_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          do_push, do_pop;

    // A pop frees a slot in the same cycle, so a push into a full FIFO is legal then.
    always_comb begin
        do_pop  = pop_i && (cnt_q != '0);
        do_push = push_i && ((cnt_q != FULL_CNT) || do_pop);
        wr_d    = do_push ? wr_q + AW'(1) : wr_q;
        rd_d    = do_pop  ? rd_q + AW'(1) : rd_q;
        cnt_d   = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_q] <= din_i;
        end
    end

    assign dout_o  = mem_q[rd_q];
    assign count_o = cnt_q;
    assign full_o  = (cnt_q == FULL_CNT);
    assign empty_o = (cnt_q == '0);

endmodule

// File: rtl/audio_i2s_tx.sv
// Mono (L = R) I2S transmitter fed by a sample FIFO after radio_core.
// Optional 50 us de-emphasis is enabled by defining DEEMPH_EN.
module audio_i2s_tx
    import radio_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        en_a,
    input  logic [15:0] demodulated,
    input  logic        mute,
    input  logic        status_clr,
    output logic        i2s_bclk,
    output logic        i2s_lrclk,
    output logic        i2s_sdata,
    output logic        underflow,
    output logic        overflow
);

    localparam int unsigned HW = $clog2(BCLK_HALF);
    localparam int unsigned BW = $clog2(FRAME_BITS);
    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    logic [HW-1:0] half_q, half_d;
    logic          bclk_q, bclk_d;
    logic [BW-1:0] bit_q, bit_d;
    logic          sdata_q, sdata_d;
    logic          uf_q, uf_d, of_q, of_d;
    logic          push_q;
    sample_t       samp_q, samp_d;
    sample_t       cur_q, cur_d;
    i2s_state_t    state_q, state_d;

    logic          fall, boundary, pop, uf_set, of_set;
    logic [BW-1:0] slot_j;
    logic [3:0]    idx;
    logic [CW-1:0] fifo_count;
    logic          fifo_full, fifo_empty;
    sample_t       fifo_dout;

    always_comb begin
        half_d = half_q + HW'(1);
        bclk_d = bclk_q;
        bit_d  = bit_q;
        fall   = 1'b0;
        if (half_q == HW'(BCLK_HALF - 1)) begin
            half_d = '0;
            bclk_d = ~bclk_q;
            fall   = bclk_q;
        end
        boundary = fall && (bit_q == BW'(FRAME_BITS - 1));
        if (fall) begin
            bit_d = boundary ? '0 : bit_q + BW'(1);
        end
    end

    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        if (boundary) begin
            case (state_q)
                IDLE: begin
                    if (fifo_count >= CW'(PREFILL)) begin
                        state_d = RUN;
                        pop     = 1'b1;
                    end
                end
                RUN:     pop = 1'b1;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        cur_d  = cur_q;
        uf_set = 1'b0;
        if (pop) begin
            if (fifo_empty) begin
                uf_set = 1'b1;
            end else begin
                cur_d = fifo_dout;
            end
        end
        of_set = push_q && fifo_full && !pop;
        uf_d   = uf_set | (uf_q & ~status_clr);
        of_d   = of_set | (of_q & ~status_clr);
    end

    // Data for the bit about to start is prepared on the bclk falling edge.
    always_comb begin
        slot_j  = (bit_d >= BW'(SLOT_BITS)) ? bit_d - BW'(SLOT_BITS) : bit_d;
        idx     = 4'(BW'(AUDIO_W) - slot_j);
        sdata_d = sdata_q;
        if (fall) begin
            sdata_d = 1'b0;
            if ((state_q == RUN) && !mute && (slot_j >= BW'(1)) && (slot_j <= BW'(AUDIO_W))) begin
                sdata_d = cur_q[idx];
            end
        end
    end

`ifdef DEEMPH_EN
    localparam logic signed [32:0] ALPHA_Q = 33'(DEEMPH_ALPHA);
    logic signed [16:0] de_diff;
    logic signed [32:0] de_prod, de_sum;

    // samp_q doubles as the filter state y.
    always_comb begin
        de_diff = {demodulated[15], demodulated} - {samp_q[15], samp_q};
        de_prod = 33'(de_diff) * ALPHA_Q;
        de_sum  = 33'(samp_q) + (de_prod >>> 15);
        samp_d  = en_a ? sat16(de_sum) : samp_q;
    end
`else
    always_comb begin
        samp_d = en_a ? sample_t'(demodulated) : samp_q;
    end
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            half_q  <= '0;
            bclk_q  <= 1'b0;
            bit_q   <= '0;
            sdata_q <= 1'b0;
            uf_q    <= 1'b0;
            of_q    <= 1'b0;
            push_q  <= 1'b0;
            samp_q  <= '0;
            cur_q   <= '0;
            state_q <= IDLE;
        end else begin
            half_q  <= half_d;
            bclk_q  <= bclk_d;
            bit_q   <= bit_d;
            sdata_q <= sdata_d;
            uf_q    <= uf_d;
            of_q    <= of_d;
            push_q  <= en_a;
            samp_q  <= samp_d;
            cur_q   <= cur_d;
            state_q <= state_d;
        end
    end

    sample_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (AUDIO_W)
    ) u_fifo (
        .clk_i   (clk),
        .rst_ni  (reset),
        .push_i  (push_q),
        .din_i   (samp_q),
        .pop_i   (pop),
        .dout_o  (fifo_dout),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign i2s_bclk  = bclk_q;
    assign i2s_lrclk = (bit_q >= BW'(SLOT_BITS));
    assign i2s_sdata = sdata_q;
    assign underflow = uf_q;
    assign overflow  = of_q;

endmodule
